symbol_integrator: RTL and testbench

//  Integrate-and-dump stage feeding the symbol decoder: accumulates signed I/Q samples

---
 rtl/symbol_integrator_pkg.sv | 19 +
 rtl/sat_narrow.sv | 37 +++
 rtl/symbol_integrator.sv | 146 ++++++++++++++
 tb/tb_symbol_integrator.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/symbol_integrator_pkg.sv
// Shared types and width helpers for the symbol integrator.
// Holds the FSM state enum and the default parameter values.
package symbol_integrator_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        INTEG = 1'b1
    } state_e;

    localparam int DIN_W_DEF = 6;
    localparam int SUM_W_DEF = 10;
    localparam int SPS_DEF   = 16;

    // Accumulator width that cannot overflow over one full window.
    function automatic int acc_width(input int din_w, input int sps);
        return din_w + $clog2(sps) + 1;
    endfunction

endpackage

// File: rtl/sat_narrow.sv
// Narrows a signed accumulator value to the decoder width.
// INTEG_SAT_EN defined: clamp to range; undefined: keep LSBs (wrap).
module sat_narrow #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] dout_o
);

`ifdef INTEG_SAT_EN
    localparam logic signed [IN_W-1:0] MAXV =
        {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MINV =
        {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Clamp out-of-range sums to the nearest representable value.
    always_comb begin
        dout_o = din_i[OUT_W-1:0];
        if (din_i > MAXV) begin
            dout_o = MAXV[OUT_W-1:0];
        end else if (din_i < MINV) begin
            dout_o = MINV[OUT_W-1:0];
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^din_i[IN_W-1:OUT_W];

    // Two's-complement wrap: the upper bits are simply dropped.
    always_comb begin
        dout_o = din_i[OUT_W-1:0];
    end
`endif

endmodule

// File: rtl/symbol_integrator.sv
// Integrate-and-dump over SPS valid samples with result strobe and lock flag.
// Output narrowing saturates when INTEG_SAT_EN is defined, else wraps.
module symbol_integrator
    import symbol_integrator_pkg::*;
#(
    parameter int DIN_W = DIN_W_DEF,
    parameter int SUM_W = SUM_W_DEF,
    parameter int SPS   = SPS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_valid,
    input  logic signed [DIN_W-1:0] din_I,
    input  logic signed [DIN_W-1:0] din_Q,
    input  logic                    sync_start,
    input  logic                    sync_clear,
    output logic signed [SUM_W-1:0] sum_I,
    output logic signed [SUM_W-1:0] sum_Q,
    output logic                    result_ok,
    output logic                    flag
);

    localparam int ACC_W = acc_width(DIN_W, SPS);
    localparam int CNT_W = $clog2(SPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acci_q, acci_d;
    logic signed [ACC_W-1:0] accq_q, accq_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] dini_x, dinq_x;
    logic signed [ACC_W-1:0] addi, addq;
    logic signed [SUM_W-1:0] nari, narq;
    logic signed [SUM_W-1:0] sumi_q, sumq_q;
    logic                    dump, dump_q;
    logic                    ok_q, flag_q;

    assign dini_x = ACC_W'(din_I);
    assign dinq_x = ACC_W'(din_Q);
    assign addi   = acci_q + dini_x;
    assign addq   = accq_q + dinq_x;

    sat_narrow #(.IN_W(ACC_W), .OUT_W(SUM_W)) u_nar_i (
        .din_i  (addi),
        .dout_o (nari)
    );

    sat_narrow #(.IN_W(ACC_W), .OUT_W(SUM_W)) u_nar_q (
        .din_i  (addq),
        .dout_o (narq)
    );

    // Next state: clear beats dump, dump beats restart, restart beats add.
    always_comb begin
        state_d = state_q;
        acci_d  = acci_q;
        accq_d  = accq_q;
        cnt_d   = cnt_q;
        dump    = 1'b0;
        if (sync_clear) begin
            state_d = IDLE;
            acci_d  = '0;
            accq_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sync_start) begin
                        state_d = INTEG;
                        acci_d  = '0;
                        accq_d  = '0;
                        cnt_d   = '0;
                    end
                end
                INTEG: begin
                    if (sample_valid && cnt_q == LAST) begin
                        dump   = 1'b1;
                        acci_d = '0;
                        accq_d = '0;
                        cnt_d  = '0;
                    end else if (sync_start) begin
                        acci_d = sample_valid ? dini_x : '0;
                        accq_d = sample_valid ? dinq_x : '0;
                        cnt_d  = sample_valid ? CNT_W'(1) : '0;
                    end else if (sample_valid) begin
                        acci_d = addi;
                        accq_d = addq;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Window state: FSM, accumulators and sample counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acci_q  <= '0;
            accq_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acci_q  <= acci_d;
            accq_q  <= accq_d;
            cnt_q   <= cnt_d;
        end
    end

    // Dump registers: sums load on dump and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sumi_q <= '0;
            sumq_q <= '0;
            dump_q <= 1'b0;
        end else begin
            dump_q <= dump;
            if (dump) begin
                sumi_q <= nari;
                sumq_q <= narq;
            end
        end
    end

    // Strobe one cycle after the sums settle; lock rises with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            ok_q <= dump_q && !sync_clear;
            if (sync_clear) begin
                flag_q <= 1'b0;
            end else if (dump_q) begin
                flag_q <= 1'b1;
            end
        end
    end

    assign sum_I     = sumi_q;
    assign sum_Q     = sumq_q;
    assign result_ok = ok_q;
    assign flag      = flag_q;

endmodule

// File: tb/tb_symbol_integrator.sv
// Scoreboard bench for symbol_integrator (SPS=16 main DUT, SPS=32 overflow DUT).
// Expected sums follow INTEG_SAT_EN the same way the build does.
module tb_symbol_integrator;

    localparam int DIN_W = 6;
    localparam int SUM_W = 10;
    localparam int SPS   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic                    sample_valid = 1'b0;
    logic signed [DIN_W-1:0] din_I = '0;
    logic signed [DIN_W-1:0] din_Q = '0;
    logic                    sync_start = 1'b0;
    logic                    sync_clear = 1'b0;
    logic signed [SUM_W-1:0] sum_I, sum_Q;
    logic                    result_ok, flag;

    logic                    b_valid = 1'b0;
    logic signed [DIN_W-1:0] b_din_I = '0;
    logic signed [DIN_W-1:0] b_din_Q = '0;
    logic                    b_start = 1'b0;
    logic signed [SUM_W-1:0] b_sum_I, b_sum_Q;
    logic                    b_ok, b_flag;

    symbol_integrator #(.DIN_W(DIN_W), .SUM_W(SUM_W), .SPS(SPS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .din_I        (din_I),
        .din_Q        (din_Q),
        .sync_start   (sync_start),
        .sync_clear   (sync_clear),
        .sum_I        (sum_I),
        .sum_Q        (sum_Q),
        .result_ok    (result_ok),
        .flag         (flag)
    );

    symbol_integrator #(.DIN_W(DIN_W), .SUM_W(SUM_W), .SPS(32)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (b_valid),
        .din_I        (b_din_I),
        .din_Q        (b_din_Q),
        .sync_start   (b_start),
        .sync_clear   (1'b0),
        .sum_I        (b_sum_I),
        .sum_Q        (b_sum_Q),
        .result_ok    (b_ok),
        .flag         (b_flag)
    );

    int checks = 0;
    int failures = 0;
    int qi[$];
    int qq[$];
    int n_push = 0;
    int n_strobe = 0;

    bit m_on = 0;
    int m_acc_i = 0;
    int m_acc_q = 0;
    int m_cnt = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int nar(input int x);
        int hi;
        int y;
        hi = 2 ** (SUM_W - 1);
`ifdef INTEG_SAT_EN
        y = x;
        if (x > hi - 1) y = hi - 1;
        if (x < -hi) y = -hi;
`else
        y = x & (2 * hi - 1);
        if (y >= hi) y = y - 2 * hi;
`endif
        return y;
    endfunction

    task automatic model_reset();
        m_on = 0;
        m_acc_i = 0;
        m_acc_q = 0;
        m_cnt = 0;
    endtask

    // Drive one cycle on the main DUT and advance the reference model.
    task automatic step(input bit v, input int di, input int dq,
                        input bit s, input bit c);
        sample_valid = v;
        din_I = DIN_W'(di);
        din_Q = DIN_W'(dq);
        sync_start = s;
        sync_clear = c;
        if (c) begin
            model_reset();
        end else if (m_on) begin
            if (v && m_cnt == SPS - 1) begin
                qi.push_back(nar(m_acc_i + di));
                qq.push_back(nar(m_acc_q + dq));
                n_push++;
                m_acc_i = 0;
                m_acc_q = 0;
                m_cnt = 0;
            end else if (s) begin
                m_acc_i = v ? di : 0;
                m_acc_q = v ? dq : 0;
                m_cnt = v ? 1 : 0;
            end else if (v) begin
                m_acc_i += di;
                m_acc_q += dq;
                m_cnt++;
            end
        end else if (s) begin
            m_on = 1;
            m_acc_i = 0;
            m_acc_q = 0;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    bit ok_prev = 0;
    int prev_i = 0;
    int prev_q = 0;

    // Output monitor: every strobe pops one expected pair.
    always @(negedge clk) begin
        if (result_ok) begin
            n_strobe++;
            check("ok_pulse_width", int'(ok_prev), 0);
            check("flag_at_ok", int'(flag), 1);
            check("sum_I_stable", int'(sum_I), prev_i);
            check("sum_Q_stable", int'(sum_Q), prev_q);
            check("strobe_expected", int'(qi.size() > 0), 1);
            if (qi.size() > 0) begin
                check("sum_I", int'(sum_I), qi.pop_front());
                check("sum_Q", int'(sum_Q), qq.pop_front());
            end
        end
        ok_prev = result_ok;
        prev_i = sum_I;
        prev_q = sum_Q;
    end

    int keep_i;
    int keep_q;
    bit b_seen;
    int got_bi;
    int got_bq;

    initial begin
        // Reset with random inputs: outputs must stay at zero.
        for (int k = 0; k < 5; k++) begin
            sample_valid = 1'($urandom);
            din_I = DIN_W'($urandom);
            din_Q = DIN_W'($urandom);
            sync_start = 1'($urandom);
            sync_clear = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("rst_sum_I", int'(sum_I), 0);
        check("rst_sum_Q", int'(sum_Q), 0);
        check("rst_ok", int'(result_ok), 0);
        check("rst_flag", int'(flag), 0);
        sync_start = 0;
        sync_clear = 0;
        rst_n = 1;

        // No sync_start: samples are ignored.
        for (int k = 0; k < 20; k++) begin
            step(1, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0);
        end
        check("idle_flag", int'(flag), 0);

        // Basic window.
        step(0, 0, 0, 1, 0);
        for (int k = 0; k < SPS; k++) step(1, 3, -2, 0, 0);
        check("pre_ok_low", int'(result_ok), 0);
        check("pre_flag_low", int'(flag), 0);
        idle(1);
        check("ok_high", int'(result_ok), 1);
        check("flag_high", int'(flag), 1);
        idle(2);

        // Reset mid-window returns everything to zero.
        for (int k = 0; k < 7; k++) step(1, 5, 5, 0, 0);
        rst_n = 0;
        #1;
        check("mid_rst_sum_I", int'(sum_I), 0);
        check("mid_rst_flag", int'(flag), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        idle(2);

        // Gapped samples.
        step(0, 0, 0, 1, 0);
        for (int k = 0; k < SPS; k++) begin
            step(1, -1, 2, 0, 0);
            idle($urandom_range(0, 3));
        end
        idle(2);

        // Partial window dropped; restart on a valid sample.
        step(0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) step(1, 1, 9, 0, 0);
        step(1, 1, -1, 1, 0);
        for (int k = 0; k < SPS - 1; k++) step(1, 1, -1, 0, 0);
        idle(2);

        // sync_start on the final sample: dump plus clean restart.
        step(0, 0, 0, 1, 0);
        for (int k = 0; k < SPS - 1; k++) step(1, 2, 1, 0, 0);
        step(1, 2, 1, 1, 0);
        for (int k = 0; k < SPS; k++) step(1, -3, 4, 0, 0);
        idle(3);

        // sync_clear on the final sample wins over the dump.
        keep_i = sum_I;
        keep_q = sum_Q;
        step(0, 0, 0, 1, 0);
        for (int k = 0; k < SPS - 1; k++) step(1, 7, -5, 0, 0);
        step(1, 7, -5, 0, 1);
        idle(3);
        check("clr_flag", int'(flag), 0);
        check("clr_hold_I", int'(sum_I), keep_i);
        check("clr_hold_Q", int'(sum_Q), keep_q);

        // Overflow window on the SPS=32 instance.
        b_start = 1;
        @(posedge clk);
        #1;
        b_start = 0;
        for (int k = 0; k < 32; k++) begin
            b_valid = 1;
            b_din_I = DIN_W'(31);
            b_din_Q = DIN_W'(-32);
            @(posedge clk);
            #1;
        end
        b_valid = 0;
        b_seen = 0;
        for (int k = 0; k < 6 && !b_seen; k++) begin
            @(posedge clk);
            #1;
            if (b_ok) begin
                b_seen = 1;
                got_bi = b_sum_I;
                got_bq = b_sum_Q;
            end
        end
        check("b_ok_seen", int'(b_seen), 1);
        check("b_sum_I", got_bi, nar(31 * 32));
        check("b_sum_Q", got_bq, nar(-32 * 32));
        check("b_flag", int'(b_flag), 1);

        idle(4);
        check("sb_empty", qi.size(), 0);
        check("strobe_count", n_strobe, n_push);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
